core_mem_wb: RTL and testbench

Memory/writeback stage of the DSP core pipeline, sitting directly downstream of the combinational ALU. It registers the ALU result, completes LD/ST instructions through a request/acknowledge handshake to local data memory, and produces the register-file write port. It also stalls the execute stage while a memory access is outstanding.

---
 rtl/core_mem_wb_pkg.sv | 54 +++++
 rtl/core_mem_wb_timeout.sv | 32 +++
 rtl/core_mem_wb.sv | 124 ++++++++++++
 tb/tb_core_mem_wb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_wb_pkg.sv
// Shared core definitions: datapath widths, opcode constants, stage state
// encodings and the writing-set predicate used by decode and writeback.
package core_mem_wb_pkg;

   localparam int REG_SIZE      = 16;
   localparam int REG_PTR_SIZE  = 4;
   localparam int INSN_OPC_SIZE = 4;

   // Range helpers for the widths above (most significant bit index)
   localparam int REG_SIZE_RANGE      = REG_SIZE - 1;
   localparam int REG_PTR_SIZE_RANGE  = REG_PTR_SIZE - 1;
   localparam int INSN_OPC_SIZE_RANGE = INSN_OPC_SIZE - 1;

   typedef logic [INSN_OPC_SIZE_RANGE:0] opc_t;

   localparam opc_t OPC_NOP       = 4'd0;
   localparam opc_t OPC_ADD       = 4'd1;
   localparam opc_t OPC_SUB       = 4'd2;
   localparam opc_t OPC_MUL       = 4'd3;
   localparam opc_t OPC_DIV       = 4'd4;
   localparam opc_t OPC_CMPGE     = 4'd5;
   localparam opc_t OPC_RSHIFT    = 4'd6;
   localparam opc_t OPC_LSHIFT    = 4'd7;
   localparam opc_t OPC_AND       = 4'd8;
   localparam opc_t OPC_OR        = 4'd9;
   localparam opc_t OPC_XOR       = 4'd10;
   localparam opc_t OPC_SET_CONST = 4'd11;
   localparam opc_t OPC_LD        = 4'd12;
   localparam opc_t OPC_ST        = 4'd13;
   localparam opc_t OPC_BR        = 4'd14;
   localparam opc_t OPC_HALT      = 4'd15;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MEM  = 1'b1
   } state_t;

   // True for every opcode that ends in a register-file write
   function automatic logic is_writing_op(input opc_t opc);
      case (opc)
         OPC_ADD, OPC_SUB, OPC_MUL, OPC_DIV, OPC_CMPGE, OPC_RSHIFT,
         OPC_LSHIFT, OPC_AND, OPC_OR, OPC_XOR, OPC_SET_CONST, OPC_LD:
            is_writing_op = 1'b1;
         default:
            is_writing_op = 1'b0;
      endcase
   endfunction

   // True for opcodes that go through the data-memory handshake
   function automatic logic is_mem_op(input opc_t opc);
      is_mem_op = (opc == OPC_LD) || (opc == OPC_ST);
   endfunction

endpackage

// File: rtl/core_mem_wb_timeout.sv
// Cycle counter for an outstanding memory access: cleared by start, counts
// while run is high, and flags expire in the last allowed waiting cycle.
module core_mem_wb_timeout
   import core_mem_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic run,
   output logic expire
);

   localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_p1;

   // Clear on entry to the wait, then count each waiting cycle
   always_ff @(posedge clk) begin
      if (reset || start) begin
         cnt_p1 <= '0;
      end else if (run) begin
         cnt_p1 <= cnt_p1 + 1'b1;
      end
   end

   assign expire = run && (cnt_p1 == LAST);

endmodule

// File: rtl/core_mem_wb.sv
// Memory/writeback stage: registers ALU results, runs LD/ST through the
// req/ack data-memory handshake and drives the register-file write port.
// Optional feature macro: CORE_MEM_TIMEOUT_EN (abort stalled accesses).
module core_mem_wb
   import core_mem_wb_pkg::*;
#(
   parameter int MEM_ADDR_SIZE  = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        X_valid,
   output logic                        X_ready,
   input  logic [INSN_OPC_SIZE_RANGE:0] X_insn_opc,
   input  logic [REG_SIZE_RANGE:0]     X_result_ALU,
   input  logic [REG_SIZE_RANGE:0]     X_st_data,
   input  logic [REG_PTR_SIZE_RANGE:0] X_dst_ptr,
   output logic                        mem_req,
   output logic                        mem_we,
   output logic [MEM_ADDR_SIZE-1:0]    mem_addr,
   output logic [REG_SIZE_RANGE:0]     mem_wdata,
   input  logic                        mem_ack,
   input  logic [REG_SIZE_RANGE:0]     mem_rdata,
   output logic                        W_we,
   output logic [REG_PTR_SIZE_RANGE:0] W_dst_ptr,
   output logic [REG_SIZE_RANGE:0]     W_data,
   output logic                        mem_err
);

   state_t                        state;
   logic                          accept;
   logic                          mem_accept;
   logic                          timeout_hit;
   logic [REG_PTR_SIZE_RANGE:0]   ld_dst_p1;

   assign X_ready    = (state == S_IDLE) && !reset;
   assign accept     = X_valid && X_ready;
   assign mem_accept = accept && is_mem_op(X_insn_opc);

   // Destination of an in-flight load, captured when the access is accepted
   always_ff @(posedge clk) begin
      if (mem_accept) begin
         ld_dst_p1 <= X_dst_ptr;
      end
   end

`ifdef CORE_MEM_TIMEOUT_EN
   core_mem_wb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .start  (mem_accept),
      .run    (state == S_MEM),
      .expire (timeout_hit)
   );

   // Sticky error: an access was abandoned for lack of an acknowledge
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_err <= 1'b0;
      end else if ((state == S_MEM) && !mem_ack && timeout_hit) begin
         mem_err <= 1'b1;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
   assign mem_err     = 1'b0;
`endif

   // Stage FSM with registered memory-request and writeback outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         W_we      <= 1'b0;
         W_dst_ptr <= '0;
         W_data    <= '0;
      end else begin
         W_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_mem_op(X_insn_opc)) begin
                     mem_req   <= 1'b1;
                     mem_we    <= (X_insn_opc == OPC_ST);
                     mem_addr  <= X_result_ALU[MEM_ADDR_SIZE-1:0];
                     mem_wdata <= X_st_data;
                     state     <= S_MEM;
                  end else if (is_writing_op(X_insn_opc)) begin
                     W_we      <= 1'b1;
                     W_data    <= X_result_ALU;
                     W_dst_ptr <= X_dst_ptr;
                  end
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= S_IDLE;
                  if (!mem_we) begin
                     W_we      <= 1'b1;
                     W_data    <= mem_rdata;
                     W_dst_ptr <= ld_dst_p1;
                  end
               end else if (timeout_hit) begin
                  mem_req <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: begin
               state   <= S_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_mem_wb.sv
// Directed bench for core_mem_wb with hand-computed expected values.
module tb_core_mem_wb;
   import core_mem_wb_pkg::*;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        X_valid;
   logic                        X_ready;
   logic [INSN_OPC_SIZE_RANGE:0] X_insn_opc;
   logic [REG_SIZE_RANGE:0]     X_result_ALU;
   logic [REG_SIZE_RANGE:0]     X_st_data;
   logic [REG_PTR_SIZE_RANGE:0] X_dst_ptr;
   logic                        mem_req;
   logic                        mem_we;
   logic [7:0]                  mem_addr;
   logic [REG_SIZE_RANGE:0]     mem_wdata;
   logic                        mem_ack;
   logic [REG_SIZE_RANGE:0]     mem_rdata;
   logic                        W_we;
   logic [REG_PTR_SIZE_RANGE:0] W_dst_ptr;
   logic [REG_SIZE_RANGE:0]     W_data;
   logic                        mem_err;

   int errors = 0;
   int checks = 0;

   core_mem_wb #(
      .MEM_ADDR_SIZE  (8),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .X_valid      (X_valid),
      .X_ready      (X_ready),
      .X_insn_opc   (X_insn_opc),
      .X_result_ALU (X_result_ALU),
      .X_st_data    (X_st_data),
      .X_dst_ptr    (X_dst_ptr),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .W_we         (W_we),
      .W_dst_ptr    (W_dst_ptr),
      .W_data       (W_data),
      .mem_err      (mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input opc_t opc, input logic [15:0] res,
                          input logic [15:0] sd, input logic [3:0] dst);
      X_valid      = 1'b1;
      X_insn_opc   = opc;
      X_result_ALU = res;
      X_st_data    = sd;
      X_dst_ptr    = dst;
   endtask

   task automatic idle_in();
      X_valid      = 1'b0;
      X_insn_opc   = OPC_NOP;
      X_result_ALU = '0;
      X_st_data    = '0;
      X_dst_ptr    = '0;
   endtask

   initial begin
      reset     = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      idle_in();
      tick();
      tick();
      chk("rst_x_ready", X_ready, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_w_we", W_we, 0);
      chk("rst_w_data", W_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_err", mem_err, 0);
      reset = 1'b0;
      tick();
      tick();
      chk("idle_x_ready", X_ready, 1);

      // ADD 0x2A -> r3, one-cycle pulse
      present(OPC_ADD, 16'h002A, 16'h0000, 4'd3);
      tick();
      idle_in();
      chk("add_we", W_we, 1);
      chk("add_dst", W_dst_ptr, 3);
      chk("add_data", W_data, 16'h002A);
      tick();
      chk("add_we_once", W_we, 0);

      // Back-to-back XOR, SET_CONST, CMPGE
      present(OPC_XOR, 16'h1111, 16'h0000, 4'd1);
      tick();
      chk("b2b_xor_we", W_we, 1);
      chk("b2b_xor_data", W_data, 16'h1111);
      chk("b2b_xor_dst", W_dst_ptr, 1);
      chk("b2b_ready1", X_ready, 1);
      present(OPC_SET_CONST, 16'h2222, 16'h0000, 4'd2);
      tick();
      chk("b2b_set_we", W_we, 1);
      chk("b2b_set_data", W_data, 16'h2222);
      chk("b2b_set_dst", W_dst_ptr, 2);
      chk("b2b_ready2", X_ready, 1);
      present(OPC_CMPGE, 16'h0001, 16'h0000, 4'd5);
      tick();
      idle_in();
      chk("b2b_cmp_we", W_we, 1);
      chk("b2b_cmp_data", W_data, 16'h0001);
      chk("b2b_cmp_dst", W_dst_ptr, 5);
      tick();
      chk("b2b_end_we", W_we, 0);

      // Non-writing, non-memory op has no effect
      present(OPC_BR, 16'h7777, 16'h0000, 4'd8);
      tick();
      idle_in();
      chk("br_we", W_we, 0);
      chk("br_req", mem_req, 0);
      chk("br_data_hold", W_data, 16'h0001);

      // LD 0x1F3 -> addr 0xF3, ack after 3 wait cycles, rdata 0xBEEF -> r7
      present(OPC_LD, 16'h01F3, 16'hAAAA, 4'd7);
      tick();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hBEEF;
         end
         chk("ld_req", mem_req, 1);
         chk("ld_we", mem_we, 0);
         chk("ld_addr", mem_addr, 8'hF3);
         chk("ld_ready_low", X_ready, 0);
         chk("ld_no_wb", W_we, 0);
         tick();
      end
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("ld_req_drop", mem_req, 0);
      chk("ld_wb_we", W_we, 1);
      chk("ld_wb_data", W_data, 16'hBEEF);
      chk("ld_wb_dst", W_dst_ptr, 7);
      chk("ld_ready_back", X_ready, 1);
      tick();
      chk("ld_wb_once", W_we, 0);

      // ST addr 0x10 data 0x55 with immediate ack
      present(OPC_ST, 16'h0010, 16'h0055, 4'd9);
      tick();
      idle_in();
      mem_ack = 1'b1;
      chk("st_req", mem_req, 1);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 8'h10);
      chk("st_wdata", mem_wdata, 16'h0055);
      chk("st_ready_low", X_ready, 0);
      tick();
      mem_ack = 1'b0;
      chk("st_req_drop", mem_req, 0);
      chk("st_no_wb", W_we, 0);
      chk("st_ready_back", X_ready, 1);
      tick();
      chk("st_no_wb2", W_we, 0);

      // Reset during the second S_MEM cycle of an LD aborts it
      present(OPC_LD, 16'h0040, 16'h0000, 4'd4);
      tick();
      idle_in();
      chk("abort_req1", mem_req, 1);
      tick();
      chk("abort_req2", mem_req, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 16'h1234;
      chk("abort_req_low", mem_req, 0);
      chk("abort_we", W_we, 0);
      chk("abort_addr", mem_addr, 0);
      chk("abort_w_data", W_data, 0);
      chk("abort_w_dst", W_dst_ptr, 0);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("stray_ack_we", W_we, 0);
      chk("stray_ack_req", mem_req, 0);
      chk("stray_ack_ready", X_ready, 1);
      tick();
      chk("stray_ack_we2", W_we, 0);

      // LD that is never acknowledged
      present(OPC_LD, 16'h0005, 16'h0000, 4'd2);
      tick();
      idle_in();
`ifdef CORE_MEM_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         chk("to_req_held", mem_req, 1);
         chk("to_err_low", mem_err, 0);
         tick();
      end
      chk("to_req_drop", mem_req, 0);
      chk("to_err_set", mem_err, 1);
      chk("to_no_wb", W_we, 0);
      chk("to_ready", X_ready, 1);
      tick();
      chk("to_no_wb2", W_we, 0);
      chk("to_err_sticky", mem_err, 1);
`else
      for (int i = 0; i < 8; i++) begin
         chk("wait_req_held", mem_req, 1);
         chk("wait_err_low", mem_err, 0);
         chk("wait_no_wb", W_we, 0);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("wait_rst_req", mem_req, 0);
      tick();
`endif

      // A following ADD completes normally
      present(OPC_ADD, 16'h0033, 16'h0000, 4'd6);
      tick();
      idle_in();
      chk("post_add_we", W_we, 1);
      chk("post_add_data", W_data, 16'h0033);
      chk("post_add_dst", W_dst_ptr, 6);
`ifdef CORE_MEM_TIMEOUT_EN
      chk("post_add_err", mem_err, 1);
`else
      chk("post_add_err", mem_err, 0);
`endif
      tick();
      chk("post_add_once", W_we, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
